// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multi-cycle mult/div sequencer.
package muldiv_pkg;

    localparam logic [3:0] ALU_MULT = 4'b1111;
    localparam logic [3:0] ALU_DIV  = 4'b0011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_op_e;

    function automatic logic is_valid_op(input logic [3:0] ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply (LSB-first) or restoring divide (MSB-first).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  step_op_e             op,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 q_bit
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Divide leaves bit 0 clear; the caller merges q_bit into it.
    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, operand};
        if (op == STEP_MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mult/div sequencer producing HI/LO and a pipeline stall.
// Define MULDIV_SIGNED_EN for two's-complement operands (adds a FIX state).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned AW = 2 * WIDTH;

    state_e           state_q, state_d;
    step_op_e         op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    acc_q, step_acc, acc_d;
    logic [WIDTH-1:0] opd_q, mag_a, mag_b;
    logic             step_q_bit;
    logic             is_mult, is_div, accept, div0, last_iter;

    assign is_mult   = (alu_ctrl == ALU_MULT);
    assign is_div    = (alu_ctrl == ALU_DIV);
    assign accept    = (state_q == IDLE) && start && is_valid_op(alu_ctrl);
    assign div0      = is_div && (op_b == '0);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign stall     = busy | accept;

`ifdef MULDIV_SIGNED_EN
    logic          neg_q, neg_r;
    logic [AW-1:0] fix_acc;

    assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    // Restore signs: product/quotient follow sa^sb, remainder follows the dividend.
    always_comb begin
        fix_acc = acc_q;
        if (op_q == STEP_DIV) begin
            if (neg_q) fix_acc[WIDTH-1:0]  = -acc_q[WIDTH-1:0];
            if (neg_r) fix_acc[AW-1:WIDTH] = -acc_q[AW-1:WIDTH];
        end else if (neg_q) begin
            fix_acc = -acc_q;
        end
    end
`else
    assign mag_a = op_a;
    assign mag_b = op_b;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .operand  (opd_q),
        .acc_next (step_acc),
        .q_bit    (step_q_bit)
    );

    assign acc_d = step_acc | {{(AW-1){1'b0}}, step_q_bit};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (div0)         state_d = DONE;
                    else if (is_mult) state_d = MUL;
                    else              state_d = DIV;
                end
            end
            MUL, DIV: begin
`ifdef MULDIV_SIGNED_EN
                if (last_iter) state_d = FIX;
`else
                if (last_iter) state_d = DONE;
`endif
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= STEP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        div_zero <= div0;
                        op_q     <= is_div ? STEP_DIV : STEP_MUL;
`ifdef MULDIV_SIGNED_EN
                        neg_q    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_r    <= op_a[WIDTH-1];
`endif
                        if (div0) begin
                            hi <= op_a;
                            lo <= '1;
                        end else if (is_mult) begin
                            acc_q <= {{WIDTH{1'b0}}, mag_b};
                            opd_q <= mag_a;
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, mag_a};
                            opd_q <= mag_b;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
`ifndef MULDIV_SIGNED_EN
                    if (last_iter) begin
                        hi <= acc_d[AW-1:WIDTH];
                        lo <= acc_d[WIDTH-1:0];
                    end
`endif
                end
`ifdef MULDIV_SIGNED_EN
                FIX: begin
                    hi <= fix_acc[AW-1:WIDTH];
                    lo <= fix_acc[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
